// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding
// for seq_alu and its multiply/divide core.
package alu_pkg;

    localparam logic [4:0] OP_A    = 5'd0;
    localparam logic [4:0] OP_B    = 5'd1;
    localparam logic [4:0] OP_NA   = 5'd2;
    localparam logic [4:0] OP_NB   = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADC  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_XOR  = 5'd9;
    localparam logic [4:0] OP_NAND = 5'd10;
    localparam logic [4:0] OP_LSL  = 5'd11;
    localparam logic [4:0] OP_LSR  = 5'd12;
    localparam logic [4:0] OP_ASR  = 5'd13;
    localparam logic [4:0] OP_CSL  = 5'd14;
    localparam logic [4:0] OP_CSR  = 5'd15;
    localparam logic [4:0] OP_MULU = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider.
// Ports: Clock, Reset(n), load (latch a/b), step (one iteration),
// div (mode), a, b; hi/lo are the values after the next step.
module alu_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             step,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import alu_pkg::*;

    // hi_q: partial product / remainder; lo_q: multiplier / quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] df;
    logic             ge;

    always_comb begin
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        sh  = {hi_q, lo_q[WIDTH-1]};
        ge  = sh >= {1'b0, b_q};
        // when ge, the true difference is below b, so W bits suffice
        df  = sh[WIDTH-1:0] - b_q;
        if (div) begin
            hi = ge ? df : sh[WIDTH-1:0];
            lo = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi = sum[WIDTH:1];
            lo = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= a;
            b_q  <= b;
        end else if (step) begin
            hi_q <= hi;
            lo_q <= lo;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with registered result/flags and multi-cycle MULU/DIVU.
// Ports: Clock, Reset(n), Start, FunSel, WF, A, B -> ALUOut, ALUOutHi,
// FlagsOut {Z,C,N,O}, Busy, Done.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOutHi,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             wf_q;
    logic             div_q;

    logic             cin;
    logic             is_sub;
    logic [WIDTH-1:0] bb;
    logic             ci;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_n;
    logic             o_n;

    logic             is_md;
    logic             div0;
    logic             is_one;
    logic             load;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign cin    = FlagsOut[FLAG_C];
    assign is_sub = FunSel == OP_SUB;
    assign bb     = is_sub ? ~B : B;
    assign ci     = is_sub | ((FunSel == OP_ADC) & cin);
    assign sum    = {1'b0, A} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};

    assign is_md  = (FunSel == OP_MULU) || (FunSel == OP_DIVU);
    assign div0   = (FunSel == OP_DIVU) && (B == '0);
    assign is_one = FunSel <= OP_CSR;
    assign load   = Start && (state != ST_RUN) && is_md && !div0;

    always_comb begin
        res = '0;
        c_n = cin;
        o_n = FlagsOut[FLAG_O];
        case (FunSel)
            OP_A:    res = A;
            OP_B:    res = B;
            OP_NA:   res = ~A;
            OP_NB:   res = ~B;
            OP_ADD, OP_ADC, OP_SUB: begin
                res = sum[WIDTH-1:0];
                c_n = sum[WIDTH];
                o_n = (A[WIDTH-1] == bb[WIDTH-1]) &&
                      (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_XOR:  res = A ^ B;
            OP_NAND: res = ~(A & B);
            OP_LSL: begin
                res = A << 1;
                c_n = A[WIDTH-1];
            end
            OP_LSR: begin
                res = A >> 1;
                c_n = A[0];
            end
            OP_ASR: begin
                res = {A[WIDTH-1], A[WIDTH-1:1]};
                c_n = A[0];
            end
            OP_CSL: begin
                res = {A[WIDTH-2:0], cin};
                c_n = A[WIDTH-1];
            end
            OP_CSR: begin
                res = {cin, A[WIDTH-1:1]};
                c_n = A[0];
            end
            default: res = '0;
        endcase
    end

    alu_muldiv_core #(.WIDTH(WIDTH)) u_md (
        .Clock (Clock),
        .Reset (Reset),
        .load  (load),
        .step  (state == ST_RUN),
        .div   (div_q),
        .a     (A),
        .b     (B),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wf_q     <= 1'b0;
            div_q    <= 1'b0;
            ALUOut   <= '0;
            ALUOutHi <= '0;
            FlagsOut <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            Busy <= 1'b0;
            case (state)
                ST_RUN: begin
                    Busy <= 1'b1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        state    <= ST_DONE;
                        ALUOut   <= md_lo;
                        ALUOutHi <= md_hi;
                        if (wf_q && div_q) begin
                            FlagsOut[FLAG_Z] <= md_lo == '0;
                            FlagsOut[FLAG_O] <= 1'b0;
                        end else if (wf_q) begin
                            FlagsOut[FLAG_Z] <= {md_hi, md_lo} == '0;
                            FlagsOut[FLAG_C] <= md_hi != '0;
                            FlagsOut[FLAG_O] <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (Start) begin
                        wf_q  <= WF;
                        div_q <= FunSel == OP_DIVU;
                        state <= ST_DONE;
                        Done  <= 1'b1;
                        if (load) begin
                            state <= ST_RUN;
                            Busy  <= 1'b1;
                            Done  <= 1'b0;
                            cnt   <= '0;
                        end else if (div0) begin
                            ALUOut   <= '1;
                            ALUOutHi <= A;
                            if (WF) begin
                                FlagsOut[FLAG_Z] <= 1'b0;
                                FlagsOut[FLAG_O] <= 1'b1;
                            end
                        end else if (is_one) begin
                            ALUOut   <= res;
                            ALUOutHi <= '0;
                            if (WF) begin
                                FlagsOut[FLAG_Z] <= res == '0;
                                FlagsOut[FLAG_C] <= c_n;
                                FlagsOut[FLAG_N] <= res[WIDTH-1];
                                FlagsOut[FLAG_O] <= o_n;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the datapath ALU. It adds a generic operand width and registered results and flags.
- It also adds multi-cycle unsigned multiply and divide, with a Start/Busy/Done handshake.
- It sits between the register-file output muxes and the ALU output mux.
- The control unit issues one operation per Start and waits for Done.

Parameters:
- WIDTH, 16, operand/result width in bits; legal values are 4 or more.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  operation request; sampled only in IDLE or DONE.
- FunSel  in  5  operation code (see Behaviour).
- WF  in  1  write-flags enable, latched with Start.
- A  in  WIDTH  operand A, latched with Start.
- B  in  WIDTH  operand B, latched with Start.
- ALUOut  out  WIDTH  registered result: low product or quotient.
- ALUOutHi  out  WIDTH  registered high product or remainder; zero for single-cycle ops.
- FlagsOut  out  4  registered {Z,C,N,O}.
- Busy  out  1  high while a multi-cycle op iterates.
- Done  out  1  one-cycle pulse when the result and flags are valid.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state IDLE;
  - ALUOut, ALUOutHi, FlagsOut, Busy, Done, iteration counter all 0.
- Reset mid-operation aborts the op; no Done is produced.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + Start, single-cycle op: compute from A, B and the current FlagsOut[C]; write results; go to DONE.
  - IDLE/DONE + Start, MULU or DIVU with B≠0: latch operands; counter=0; go to RUN.
  - IDLE/DONE + Start, DIVU with B=0: go to DONE.
  - RUN: one iteration per clock. On iteration WIDTH, write results and go to DONE.
  - DONE with no Start: go to IDLE.
- Handshakes:
  - Done=1 exactly while in DONE.
  - Busy=1 exactly while in RUN.
  - Start in RUN is ignored.
  - Back-to-back Start while in DONE is accepted.
- Latency:
  - Single-cycle ops: Done is high in the cycle after the Start edge.
  - MULU/DIVU: Busy is high for WIDTH cycles; Done is high WIDTH+1 cycles after the Start edge.
- Opcodes (FunSel). All ops are full width; ALUOutHi=0 for single-cycle ops.
  - 0 A, 1 B, 2 ~A, 3 ~B.
  - 4 A+B, 5 A+B+C, 6 A-B (computed as A+~B+1).
  - 7 AND, 8 OR, 9 XOR, 10 NAND.
  - 11 LSL, 12 LSR, 13 ASR (MSB preserved).
  - 14 CSL {A[W-2:0],C}, 15 CSR {C,A[W-1:1]}.
  - 16 MULU: {ALUOutHi,ALUOut} = A*B, shift-add.
  - 17 DIVU: ALUOut = A/B, ALUOutHi = A%B, restoring division.
  - 18-31 reserved: go to DONE with outputs and flags unchanged.
- Flags are written only if the latched WF=1, on the same edge as the result. Unlisted flags hold.
  - Z = (ALUOut==0) for all non-reserved ops, except MULU, where Z = (full product==0).
  - N = ALUOut[WIDTH-1] for ops 0-15.
  - Add/sub: C = carry out of the WIDTH+1-bit sum; for subtract, C=1 means no borrow.
  - Add/sub: O = signed overflow of the same sum.
  - Shifts and rotates: C = the bit shifted out.
  - MULU: C = (ALUOutHi≠0); O=0.
  - DIVU: O = (B==0); C and N hold.
  - DIVU with B=0: ALUOut = all ones, ALUOutHi = A, Z=0.
- Arithmetic is unsigned modulo 2^WIDTH. The counter width is $clog2(WIDTH+1).

Decomposition:
- Package alu_pkg:
  - FunSel opcode localparams (OP_ADD … OP_DIVU);
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0;
  - state encoding constants.
- Sub-module alu_muldiv_core (parameter WIDTH) holds the shift-add and restoring-divide registers and iteration logic.
  - Controlled by load/step inputs from seq_alu's FSM.
  - Returns hi/lo results.
- seq_alu owns the FSM, the single-cycle combinational ops, and the flag and output registers.

Test Plan:
- WIDTH=16, ADD A=0x7FFF B=0x0001 WF=1 → Done high 1 cycle after the Start edge; ALUOut=0x8000; FlagsOut=4'b0011.
- SUB A=0x0005 B=0x0005 WF=1 → ALUOut=0x0000, FlagsOut=4'b1100. Then a back-to-back Start in DONE (CSL, A=0x8000, WF=0) → ALUOut=0x0001, FlagsOut stays 4'b1100.
- MULU A=0x1234 B=0x0100 WF=1 → Busy high 16 cycles; Done 17 cycles after the Start edge; ALUOut=0x3400; ALUOutHi=0x0012; Z=0, C=1, O=0.
- DIVU A=100 B=7 → ALUOut=0x000E, ALUOutHi=0x0002, O=0. DIVU A=0x1234 B=0 → Done after 1 cycle; ALUOut=0xFFFF; ALUOutHi=0x1234; O=1.
- Start MULU, then pulse Start with ADD in cycle 5 → the ADD is ignored and the MULU result is correct. Assert Reset in cycle 8 of a second MULU → all outputs 0 immediately; no Done.
- Reserved FunSel=20 → Done after 1 cycle; ALUOut and FlagsOut unchanged. Repeat the ADD case with WIDTH=8 (A=0x7F, B=0x01) → ALUOut=0x80, FlagsOut=4'b0011.
